truth_table_sweeper: RTL
========================

# truth_table_sweeper

Sequencer that runs a 3-input combinational circuit-under-test through its full truth table. On `start` it drives each input combination {in1,in2,in3} = 0..7 in order, waits a settle interval, samples the circuit output several times, and builds a measured 8-bit truth table. It compares that table with an expected table (for example 8'h42) and reports per-row mismatches plus an overall pass flag. It sits between the test controller and each tested circuit, so it is the only block that drives that circuit's inputs.

## Interface
- `SETTLE_CYCLES`, default 16: cycles held after each input change before sampling; legal range 1..65535.
- `SAMPLES`, default 4: consecutive samples taken per row; legal range 1..255.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a sweep; accepted only in IDLE.
- `expected`  in  8  expected truth table; bit i is the expected output for input i; latched when `start` is accepted.
- `dut_in`  out  3  {in1,in2,in3} driven to the circuit-under-test; registered.
- `dut_out`  in  1  circuit output, asynchronous to `clk`.
- `busy`  out  1  high while a sweep is running.
- `done`  out  1  one-cycle pulse when the results become valid.
- `measured`  out  8  measured truth table.
- `unstable`  out  8  bit i set if the samples for row i disagreed.
- `mismatch`  out  8  (`measured` ^ latched `expected`) | `unstable`.
- `pass`  out  1  `mismatch` == 0.

## Operation
- `dut_out` passes through a 2-flop synchronizer. The settle interval must absorb its 2-cycle delay; this is the integrator's responsibility.
- States:
  - IDLE: `start`=1 latches `expected`, clears `measured`, `unstable`, `mismatch` and `pass`, sets row=0, then goes to SETTLE.
  - SETTLE: `dut_in`=row. Lasts exactly `SETTLE_CYCLES` cycles, then goes to SAMPLE.
  - SAMPLE: lasts exactly `SAMPLES` cycles and takes one synchronized sample per cycle.
    - The first sample is the row's reference value. Any later sample that differs sets `unstable[row]`.
    - On the last cycle, `measured[row]` ← first sample.
    - If row<7: row increments and the FSM goes to SETTLE.
    - If row=7: the FSM goes to REPORT.
  - REPORT: one cycle. `done`=1, and `mismatch` and `pass` are computed from the final tables. Then goes to IDLE.
- `measured`, `unstable`, `mismatch` and `pass` hold after REPORT until the next `start` is accepted.
- `start` is ignored while `busy` is high. `expected` changes after acceptance have no effect.
- `dut_in` keeps its value 3'b111 in IDLE after a sweep completes, and is 0 after reset.
- Row order is strictly ascending 0..7 with no wrap. The row counter is 3 bits; row 7 exits on the row==7 test, not on overflow.
- Reset mid-sweep: asynchronous return to IDLE, all outputs at their reset values, partial results discarded.

## Timing
- Reset values: `dut_in`=0, `busy`=0, `done`=0, `measured`=0, `unstable`=0, `mismatch`=0, `pass`=0.
- Call the `start`-accept edge cycle T.
  - `busy` and the first SETTLE begin at T+1.
  - Each row occupies `SETTLE_CYCLES`+`SAMPLES` cycles.
  - REPORT (`done`=1, `busy`=0) occurs at T+1+8·(`SETTLE_CYCLES`+`SAMPLES`).
  - Defaults: `done` at T+161.
- `dut_in` changes only on the first SETTLE cycle of each row.
- A `start` held high through REPORT is accepted in the IDLE cycle that follows, so back-to-back sweeps are separated by exactly one IDLE cycle.
- `pass`, `mismatch`, `measured` and `unstable` are valid from the REPORT cycle onward.

## Structure
- `sweeper_pkg` holds:
  - the state enum (IDLE, SETTLE, SAMPLE, REPORT);
  - `ROWS`=8 and `IN_W`=3;
  - the settle-counter width `SETTLE_W`=16 and the sample-counter width `SAMPLE_W`=8.
- Sub-module `sync2`: the 2-flop synchronizer for `dut_out`, reset to 0.
- The FSM, counters and result registers live in `truth_table_sweeper`.

## Test plan
- Behavioural model implementing 0x42 (output 1 only for inputs 001 and 110), `expected`=8'h42, defaults: `measured`=8'h42, `mismatch`=0, `pass`=1, `done` exactly at T+161, `dut_in` stepping 0..7.
- Same model, `expected`=8'h43: `mismatch`=8'h01, `pass`=0.
- Model output forced to toggle during row 5's SAMPLE window: `unstable`=8'h20, `mismatch[5]`=1, `pass`=0.
- `start` pulsed during row 3 and `expected` changed mid-sweep: sweep is unaffected, results match the originally latched table, and exactly one `done` occurs.
- `rst` asserted at row 4: outputs go to 0 immediately. A fresh `start` then gives a complete, correct sweep.
- `SETTLE_CYCLES`=1, `SAMPLES`=1, `start` held high: `done` at T+17, a second sweep is accepted the cycle after REPORT, and `done` repeats every 18 cycles.

Source files
------------

// File: rtl/truth_table_sweeper_pkg.sv
// Shared definitions for the truth-table sweeper.
//   - sweep_state_e : sequencer states (IDLE, SETTLE, SAMPLE, REPORT)
//   - ROWS / IN_W   : table size and circuit-under-test input width
//   - SETTLE_W / SAMPLE_W : widths of the settle and sample counters
//   - row_bit()     : one-hot mask selecting a single table row
package sweeper_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        REPORT = 2'd3
    } sweep_state_e;

    localparam int ROWS     = 8;
    localparam int IN_W     = 3;
    localparam int SETTLE_W = 16;
    localparam int SAMPLE_W = 8;

    localparam logic [IN_W-1:0] LAST_ROW = IN_W'(ROWS - 1);

    function automatic logic [ROWS-1:0] row_bit(input logic [IN_W-1:0] row);
        return ROWS'(1) << row;
    endfunction

endpackage

// File: rtl/truth_table_sweeper_sync2.sv
// Two-flop synchronizer bringing the circuit-under-test output into the
// sweeper clock domain.
//   clk  : sampling clock
//   rst  : asynchronous active-high reset, both flops clear to 0
//   d_i  : asynchronous input
//   q_o  : synchronized output, two clock cycles of latency
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: drives a 3-input circuit-under-test through input
// combinations 0..7, waits SETTLE_CYCLES after each change, takes SAMPLES
// synchronized samples, and compares the measured table to an expected one.
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   start    : sweep request, accepted only in IDLE
//   expected : expected table (bit i = output for input i), latched on start
//   dut_in   : registered inputs {in1,in2,in3} to the circuit-under-test
//   dut_out  : circuit output, asynchronous to clk
//   busy     : sweep in progress (SETTLE or SAMPLE)
//   done     : one-cycle pulse in REPORT, results valid from then on
//   measured : measured table (first sample of each row)
//   unstable : bit i set when row i's samples disagreed
//   mismatch : (measured ^ expected) | unstable
//   pass     : mismatch == 0
module truth_table_sweeper
    import sweeper_pkg::*;
#(
    parameter int SETTLE_CYCLES = 16,
    parameter int SAMPLES       = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [ROWS-1:0] expected,
    output logic [IN_W-1:0] dut_in,
    input  logic            dut_out,
    output logic            busy,
    output logic            done,
    output logic [ROWS-1:0] measured,
    output logic [ROWS-1:0] unstable,
    output logic [ROWS-1:0] mismatch,
    output logic            pass
);

    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [SAMPLE_W-1:0] SAMPLE_LAST = SAMPLE_W'(SAMPLES - 1);

    sweep_state_e         state_q, state_d;
    logic [IN_W-1:0]      row_q, row_d;
    logic [SETTLE_W-1:0]  settle_cnt_q, settle_cnt_d;
    logic [SAMPLE_W-1:0]  sample_cnt_q, sample_cnt_d;
    logic                 ref_q, ref_d;
    logic [IN_W-1:0]      dut_in_q, dut_in_d;
    logic [ROWS-1:0]      expected_q, expected_d;
    logic [ROWS-1:0]      measured_q, measured_d;
    logic [ROWS-1:0]      unstable_q, unstable_d;
    logic [ROWS-1:0]      mismatch_q, mismatch_d;
    logic                 pass_q, pass_d;

    logic dut_sync;
    logic last_settle;
    logic first_sample;
    logic last_sample;

    sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (dut_out),
        .q_o (dut_sync)
    );

    assign last_settle  = (settle_cnt_q == SETTLE_LAST);
    assign first_sample = (sample_cnt_q == '0);
    assign last_sample  = (sample_cnt_q == SAMPLE_LAST);

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start)       state_d = SETTLE;
            SETTLE:  if (last_settle) state_d = SAMPLE;
            SAMPLE:  if (last_sample) state_d = (row_q == LAST_ROW) ? REPORT : SETTLE;
            REPORT:                   state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy = (state_q == SETTLE) || (state_q == SAMPLE);
        done = (state_q == REPORT);
    end

    // Counters and result tables
    always_comb begin
        row_d        = row_q;
        settle_cnt_d = settle_cnt_q;
        sample_cnt_d = sample_cnt_q;
        ref_d        = ref_q;
        dut_in_d     = dut_in_q;
        expected_d   = expected_q;
        measured_d   = measured_q;
        unstable_d   = unstable_q;
        mismatch_d   = mismatch_q;
        pass_d       = pass_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    expected_d   = expected;
                    measured_d   = '0;
                    unstable_d   = '0;
                    mismatch_d   = '0;
                    pass_d       = 1'b0;
                    row_d        = '0;
                    dut_in_d     = '0;
                    settle_cnt_d = '0;
                    sample_cnt_d = '0;
                end
            end

            SETTLE: begin
                settle_cnt_d = last_settle ? '0 : settle_cnt_q + SETTLE_W'(1);
            end

            SAMPLE: begin
                // The first sample of a row is its reference; any later
                // disagreement marks the row unstable.
                if (first_sample) begin
                    ref_d = dut_sync;
                end else if (dut_sync != ref_q) begin
                    unstable_d = unstable_q | row_bit(row_q);
                end

                sample_cnt_d = last_sample ? '0 : sample_cnt_q + SAMPLE_W'(1);

                if (last_sample) begin
                    // With a single sample per row the reference register
                    // has not been loaded yet, so take the live sample.
                    measured_d[row_q] = first_sample ? dut_sync : ref_q;
                    if (row_q != LAST_ROW) begin
                        row_d    = row_q + IN_W'(1);
                        dut_in_d = row_q + IN_W'(1);
                    end else begin
                        // Final verdict is registered on entry to REPORT so it
                        // is already visible during the done pulse.
                        mismatch_d = (measured_d ^ expected_q) | unstable_d;
                        pass_d     = (mismatch_d == '0);
                    end
                end
            end

            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q        <= '0;
            settle_cnt_q <= '0;
            sample_cnt_q <= '0;
            ref_q        <= 1'b0;
            dut_in_q     <= '0;
            expected_q   <= '0;
            measured_q   <= '0;
            unstable_q   <= '0;
            mismatch_q   <= '0;
            pass_q       <= 1'b0;
        end else begin
            row_q        <= row_d;
            settle_cnt_q <= settle_cnt_d;
            sample_cnt_q <= sample_cnt_d;
            ref_q        <= ref_d;
            dut_in_q     <= dut_in_d;
            expected_q   <= expected_d;
            measured_q   <= measured_d;
            unstable_q   <= unstable_d;
            mismatch_q   <= mismatch_d;
            pass_q       <= pass_d;
        end
    end

    assign dut_in   = dut_in_q;
    assign measured = measured_q;
    assign unstable = unstable_q;
    assign mismatch = mismatch_q;
    assign pass     = pass_q;

endmodule
